// File: rtl/pong_pkg.sv
// Shared constants and types for the pong video pipeline.
// The pixel router and its neighbours import this package.
package pong_pkg;

    localparam int PIX_W    = 12;
    localparam int H_ACTIVE = 640;
    localparam int V_ACTIVE = 480;

    // Wide enough to count every pixel of one active frame.
    localparam int FRAME_CNT_W = $clog2(H_ACTIVE * V_ACTIVE);

    localparam logic [PIX_W-1:0] BLANK_RGB = 12'h000;

    typedef enum logic [1:0] {
        WAIT_FRAME = 2'd0,
        RUN_A      = 2'd1,
        RUN_B      = 2'd2
    } state_e;

endpackage

// File: rtl/pixel_demux_if.sv
// Pixel stream bundle: one source on the inputs, two sinks on the outputs.
// master drives the source side; slave is the router.
interface pixel_demux_if import pong_pkg::*; #(parameter int WIDTH = PIX_W);

    logic [WIDTH-1:0] in_rgb;
    logic             in_valid;
    logic             frame_start;
    logic [WIDTH-1:0] outA;
    logic             outA_valid;
    logic [WIDTH-1:0] outB;
    logic             outB_valid;

    modport master (
        output in_rgb, in_valid, frame_start,
        input  outA, outA_valid, outB, outB_valid
    );

    modport slave (
        input  in_rgb, in_valid, frame_start,
        output outA, outA_valid, outB, outB_valid
    );

endinterface

// File: rtl/pixel_demux_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment together
// loads 1 so the first event of a new window is counted.
module sat_counter #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_d;
    logic [W-1:0] count_q;

    // NOTE: assign every always_comb output up front so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = inc ? W'(1) : '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pixel_demux.sv
// Frame-synchronous 1:2 pixel router; route changes take effect only at
// frame_start, and each sink's per-frame pixel count is reported.
module pixel_demux import pong_pkg::*; #(
    parameter int               WIDTH = PIX_W,
    parameter logic [WIDTH-1:0] BLANK = BLANK_RGB,
    parameter int               CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    pixel_demux_if.slave     bus,
    input  logic             sel_req,
    output logic             sel_active,
    output logic             pending,
    output logic [CNT_W-1:0] cntA,
    output logic [CNT_W-1:0] cntB
);

    state_e           state_d, state_q;
    logic [WIDTH-1:0] out_a_d, out_a_q;
    logic [WIDTH-1:0] out_b_d, out_b_q;
    logic             out_a_valid_d, out_a_valid_q;
    logic             out_b_valid_d, out_b_valid_q;
    logic             sel_active_d, sel_active_q;
    logic             pending_d, pending_q;
    logic             running;
    logic             inc_a, inc_b;

    // The frame_start cycle already uses the new route for its own pixel.
    always_comb begin
        state_d = state_q;
        if (bus.frame_start) begin
            state_d = sel_req ? RUN_B : RUN_A;
        end

        running       = (state_d != WAIT_FRAME);
        inc_a         = bus.in_valid && (state_d == RUN_A);
        inc_b         = bus.in_valid && (state_d == RUN_B);
        out_a_d       = inc_a ? bus.in_rgb : BLANK;
        out_b_d       = inc_b ? bus.in_rgb : BLANK;
        out_a_valid_d = inc_a;
        out_b_valid_d = inc_b;
        sel_active_d  = (state_d == RUN_B);
        pending_d     = running && (sel_req != sel_active_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_FRAME;
            out_a_q       <= BLANK;
            out_b_q       <= BLANK;
            out_a_valid_q <= 1'b0;
            out_b_valid_q <= 1'b0;
            sel_active_q  <= 1'b0;
            pending_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            out_a_q       <= out_a_d;
            out_b_q       <= out_b_d;
            out_a_valid_q <= out_a_valid_d;
            out_b_valid_q <= out_b_valid_d;
            sel_active_q  <= sel_active_d;
            pending_q     <= pending_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.frame_start),
        .inc   (inc_a),
        .count (cntA)
    );

    sat_counter #(.W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (bus.frame_start),
        .inc   (inc_b),
        .count (cntB)
    );

    assign bus.outA       = out_a_q;
    assign bus.outA_valid = out_a_valid_q;
    assign bus.outB       = out_b_q;
    assign bus.outB_valid = out_b_valid_q;
    assign sel_active     = sel_active_q;
    assign pending        = pending_q;

endmodule

// File: tb/tb_pixel_demux.sv
// Directed bench for pixel_demux: a default instance plus a narrow-counter
// instance sharing the same stimulus to reach saturation quickly.
module tb_pixel_demux;
    import pong_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic sel_req;
    logic sel_active, pending;
    logic [FRAME_CNT_W-1:0] cnt_a, cnt_b;
    logic sel_active_s, pending_s;
    logic [3:0] cnt_a_s, cnt_b_s;

    int total = 0;
    int bad   = 0;

    pixel_demux_if #(.WIDTH(PIX_W)) bus ();
    pixel_demux_if #(.WIDTH(PIX_W)) bus_s ();

    assign bus_s.in_rgb      = bus.in_rgb;
    assign bus_s.in_valid    = bus.in_valid;
    assign bus_s.frame_start = bus.frame_start;

    pixel_demux dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sel_req    (sel_req),
        .sel_active (sel_active),
        .pending    (pending),
        .cntA       (cnt_a),
        .cntB       (cnt_b)
    );

    pixel_demux #(.CNT_W(4)) dut_s (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_s),
        .sel_req    (sel_req),
        .sel_active (sel_active_s),
        .pending    (pending_s),
        .cntA       (cnt_a_s),
        .cntB       (cnt_b_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [11:0] a, input logic av,
                           input logic [11:0] b, input logic bv);
        check({tag, ".outA"}, 32'(bus.outA), 32'(a));
        check({tag, ".outA_valid"}, 32'(bus.outA_valid), 32'(av));
        check({tag, ".outB"}, 32'(bus.outB), 32'(b));
        check({tag, ".outB_valid"}, 32'(bus.outB_valid), 32'(bv));
    endtask

    task automatic chk_cnt(input string tag, input int a, input int b);
        check({tag, ".cntA"}, 32'(cnt_a), a);
        check({tag, ".cntB"}, 32'(cnt_b), b);
    endtask

    // Drive one input slot, then step past the capturing edge.
    task automatic drive(input logic fs, input logic sel, input logic vld, input logic [11:0] rgb);
        bus.frame_start = fs;
        sel_req         = sel;
        bus.in_valid    = vld;
        bus.in_rgb      = rgb;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        drive(1'b0, 1'b0, 1'b0, 12'h000);
        chk_out("reset", 12'h000, 1'b0, 12'h000, 1'b0);
        check("reset.sel_active", 32'(sel_active), 0);
        check("reset.pending", 32'(pending), 0);
        chk_cnt("reset", 0, 0);
        rst = 1'b0;

        // Pixels before the first frame_start are dropped.
        drive(1'b0, 1'b0, 1'b1, 12'hABC);
        chk_out("preframe", 12'h000, 1'b0, 12'h000, 1'b0);
        chk_cnt("preframe", 0, 0);
        check("preframe.pending", 32'(pending), 0);
        drive(1'b0, 1'b1, 1'b1, 12'hABC);
        check("preframe.pending_sel1", 32'(pending), 0);
        check("preframe.sel_active", 32'(sel_active), 0);

        // Frame to A with five pixels.
        drive(1'b1, 1'b0, 1'b1, 12'hF00);
        chk_out("frameA0", 12'hF00, 1'b1, 12'h000, 1'b0);
        chk_cnt("frameA0", 1, 0);
        check("frameA0.sel_active", 32'(sel_active), 0);
        for (int i = 1; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b1, 12'hF00 + 12'(i));
            chk_out("frameA", 12'hF00 + 12'(i), 1'b1, 12'h000, 1'b0);
        end
        chk_cnt("frameA5", 5, 0);

        // Mid-frame request for B only raises pending.
        drive(1'b0, 1'b1, 1'b1, 12'h123);
        chk_out("pendB", 12'h123, 1'b1, 12'h000, 1'b0);
        check("pendB.pending", 32'(pending), 1);
        check("pendB.sel_active", 32'(sel_active), 0);
        chk_cnt("pendB", 6, 0);
        drive(1'b0, 1'b0, 1'b1, 12'h124);
        check("toggle0.pending", 32'(pending), 0);
        drive(1'b0, 1'b1, 1'b1, 12'h125);
        check("toggle1.pending", 32'(pending), 1);
        chk_cnt("toggle", 8, 0);

        // Boundary: new route applies to the frame_start pixel itself.
        drive(1'b1, 1'b1, 1'b1, 12'h0F0);
        chk_out("switchB", 12'h000, 1'b0, 12'h0F0, 1'b1);
        chk_cnt("switchB", 0, 1);
        check("switchB.pending", 32'(pending), 0);
        check("switchB.sel_active", 32'(sel_active), 1);

        // frame_start without a pixel, then gaps.
        drive(1'b1, 1'b1, 1'b0, 12'hEEE);
        chk_out("fs_novalid", 12'h000, 1'b0, 12'h000, 1'b0);
        chk_cnt("fs_novalid", 0, 0);
        drive(1'b0, 1'b1, 1'b1, 12'h111);
        chk_out("gap1", 12'h000, 1'b0, 12'h111, 1'b1);
        chk_cnt("gap1", 0, 1);
        drive(1'b0, 1'b1, 1'b0, 12'h222);
        chk_out("gap2", 12'h000, 1'b0, 12'h000, 1'b0);
        chk_cnt("gap2", 0, 1);
        drive(1'b0, 1'b1, 1'b1, 12'h333);
        chk_cnt("gap3", 0, 2);

        // Back-to-back frame_starts, each handled independently.
        drive(1'b1, 1'b0, 1'b1, 12'h444);
        chk_out("fs_pair0", 12'h444, 1'b1, 12'h000, 1'b0);
        chk_cnt("fs_pair0", 1, 0);
        check("fs_pair0.sel_active", 32'(sel_active), 0);
        drive(1'b1, 1'b1, 1'b1, 12'h555);
        chk_out("fs_pair1", 12'h000, 1'b0, 12'h555, 1'b1);
        chk_cnt("fs_pair1", 0, 1);
        check("fs_pair1.sel_active", 32'(sel_active), 1);

        // Saturation on the 4-bit instance: 20 pixels to A, max is 15.
        drive(1'b1, 1'b0, 1'b1, 12'h700);
        for (int i = 1; i < 15; i++) begin
            drive(1'b0, 1'b0, 1'b1, 12'h700 + 12'(i));
        end
        check("sat15.cntA_s", 32'(cnt_a_s), 15);
        for (int i = 15; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 12'h700 + 12'(i));
        end
        check("sat20.cntA_s", 32'(cnt_a_s), 15);
        check("sat20.cntB_s", 32'(cnt_b_s), 0);
        chk_cnt("sat20", 20, 0);

        // Reset mid-frame while routing to B.
        drive(1'b1, 1'b1, 1'b1, 12'h666);
        chk_out("runB", 12'h000, 1'b0, 12'h666, 1'b1);
        check("runB.cntA_s", 32'(cnt_a_s), 0);
        drive(1'b0, 1'b1, 1'b1, 12'h777);
        chk_cnt("runB", 0, 2);
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 12'h888);
        rst = 1'b0;
        chk_out("midrst", 12'h000, 1'b0, 12'h000, 1'b0);
        check("midrst.sel_active", 32'(sel_active), 0);
        check("midrst.pending", 32'(pending), 0);
        chk_cnt("midrst", 0, 0);
        drive(1'b0, 1'b1, 1'b1, 12'h999);
        chk_out("postrst", 12'h000, 1'b0, 12'h000, 1'b0);
        check("postrst.pending", 32'(pending), 0);
        chk_cnt("postrst", 0, 0);
        drive(1'b1, 1'b1, 1'b1, 12'hAAA);
        chk_out("restart", 12'h000, 1'b0, 12'hAAA, 1'b1);
        chk_cnt("restart", 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pixel_demux.md
# pixel_demux

Frame-synchronous 1-to-2 router for the 12-bit RGB pixel stream: routes one pixel source to either of two sinks (display path A or B). It is the counterpart of the 2:1 colour mux that merges sources into the VGA path. Select changes are deferred to the next frame boundary so a sink never sees a torn frame. The block also counts the pixels delivered to each sink per frame, for debug and scoreboard checks.

## Interface
Parameters:
- WIDTH, 12, pixel width (4R/4G/4B).
- BLANK, 12'h000, value driven on an inactive or invalid output.
- CNT_W, 19, per-frame pixel counter width (640×480 = 307200 < 2^19).

Ports:
- clk  in  1  system pixel clock.
- rst  in  1  synchronous, active-high reset.
- in_rgb  in  WIDTH  input pixel.
- in_valid  in  1  in_rgb is a real pixel this cycle.
- frame_start  in  1  one-cycle pulse coincident with the first pixel slot of a frame.
- sel_req  in  1  requested route: 0 selects A, 1 selects B. Level input, sampled every cycle.
- outA  out  WIDTH  pixel to sink A.
- outA_valid  out  1  outA holds a real pixel.
- outB  out  WIDTH  pixel to sink B.
- outB_valid  out  1  outB holds a real pixel.
- sel_active  out  1  route currently in force.
- pending  out  1  sel_req differs from sel_active and is waiting for a frame boundary.
- cntA, cntB  out  CNT_W  pixels delivered to A/B in the current frame.

## Operation
States:
- WAIT_FRAME: after reset, nothing is routed.
- RUN_A: routing to A.
- RUN_B: routing to B.

Transitions:
- WAIT_FRAME → RUN_A or RUN_B on the first frame_start, using the sel_req value in that cycle.
- RUN_x → RUN_y only on frame_start, using the sel_req value in that cycle. Changes to sel_req between frame_starts are ignored except through the pending flag.

Routing:
- In RUN_x, a pixel with in_valid=1 goes to out_x with out_x_valid=1.
- The other output is held at BLANK with valid=0.
- When in_valid=0, both outputs are BLANK with valid=0.

Other rules:
- pending = (state ≠ WAIT_FRAME) && (sel_req ≠ sel_active). It is 0 in WAIT_FRAME.
- sel_active reads 0 in WAIT_FRAME.
- Counters clear on frame_start.
- A counter increments on each pixel routed to its output. It saturates at 2^CNT_W−1 and does not wrap.

Boundary conditions:
- frame_start together with in_valid: that pixel is the first pixel of the new frame. It is routed using the new selection and counted as 1 in the new frame's counter.
- sel_req toggling several times within a frame: only its value at the next frame_start matters.
- frame_start pulses on consecutive cycles: each one is a boundary and is handled independently.
- rst asserted mid-frame: on the next edge all outputs go to their reset values and the state returns to WAIT_FRAME. No partial-frame pixels are delivered after reset.

## Timing
- Latency is 1 cycle. Input at edge n appears on the outputs after edge n+1, registered.
- Route decision and counter clear: the cycle carrying frame_start takes effect for that same pixel, which appears at n+1.
- sel_active and pending are registered and update on the edge after the event.
- Reset values:
  - outA = outB = BLANK
  - outA_valid = outB_valid = 0
  - sel_active = 0
  - pending = 0
  - cntA = cntB = 0
  - state = WAIT_FRAME
- Throughput is 1 pixel per cycle with no stalls. There is no backpressure: sinks must accept every valid cycle.

## Structure
- Shared package (pong_pkg) holds:
  - PIX_W = 12
  - BLANK colour constant
  - H_ACTIVE = 640 and V_ACTIVE = 480, from which CNT_W is derived
  - state enum {WAIT_FRAME, RUN_A, RUN_B}
- One natural sub-module: sat_counter, a saturating counter with synchronous clear and increment. It is instantiated twice, once for A and once for B.
- The FSM and output registers live in the top level.

## Test plan
- Reset, then frame_start with sel_req=0 and 5 valid pixels 12'hF00..12'hF04 → outA shows the same values 1 cycle later with outA_valid=1; outB=000 with outB_valid=0; cntA=5.
- Before the first frame_start, drive valid pixels 12'hABC → both outputs stay 000 with valid=0; counters stay 0; pending=0.
- In RUN_A mid-frame, set sel_req=1 → pending=1 and pixels still go to A. At the next frame_start, pixel 12'h0F0 appears on outB; cntA clears and cntB=1; pending returns to 0.
- frame_start with in_valid=0, followed by gaps in in_valid → invalid cycles give BLANK on both outputs with valid=0 and do not increment the counters.
- Force 2^19+3 valid pixels without a frame_start → cntA saturates at 524287 and does not wrap.
- Assert rst for 1 cycle mid-frame while in RUN_B → on the next cycle all outputs are at their reset values and the state is WAIT_FRAME; subsequent pixels are dropped until a frame_start.
